// File: rtl/if_stage_if.sv
// Instruction-memory handshake bundle used by the fetch stage.
//   imem_req   : request, held high until imem_ack
//   imem_addr  : fetch byte address, stable while imem_req is high
//   imem_ack   : one-cycle response strobe
//   imem_rdata : instruction word, valid with imem_ack
// master = fetch stage, slave = instruction memory.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register, one-entry skid buffer,
// load-use hazard stall, redirect handling and halt detection.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   imem (master)       : instruction-memory request/ack handshake
//   redirect_i          : taken branch/jump pulse
//   redirect_target_i   : new PC, sampled with redirect_i
//   ex_mem_read_i       : EX-stage instruction is a load
//   ex_rt_i             : destination register of that load
//   id_instruction_o    : IF/ID instruction word
//   id_pc_plus4_o       : PC+4 of id_instruction_o
//   stall_b_o           : low = decoder must treat IF/ID as a bubble
//   halted_o            : high once a halt word (opcode 6'h3f) entered IF/ID
module if_stage (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  imem,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  input  logic        ex_mem_read_i,
  input  logic [4:0]  ex_rt_i,
  output logic [31:0] id_instruction_o,
  output logic [31:0] id_pc_plus4_o,
  output logic        stall_b_o,
  output logic        halted_o
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    BUF   = 2'd1,
    DROP  = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;          // next address to fetch
  logic [31:0] addr_q;        // address presented on the bus
  logic        req_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_pc4_q;
  logic        id_valid_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_pc4_q;
  logic        skid_valid_q;
  logic        halted_q;

  logic        hazard_s;
  logic        ack_s;
  logic [31:0] pc_plus4_s;
  logic        rdata_halt_s;
  logic        skid_halt_s;

  // Load-use hazard detection and per-cycle helper values.
  always_comb begin
    hazard_s     = 1'b0;
    ack_s        = 1'b0;
    pc_plus4_s   = pc_q + 32'd4;  // modulo 2^32 wrap is intended
    rdata_halt_s = (imem.imem_rdata[31:26] == 6'h3f);
    skid_halt_s  = (skid_instr_q[31:26] == 6'h3f);
    if (ex_mem_read_i && (ex_rt_i != 5'd0) && id_valid_q &&
        ((ex_rt_i == id_instr_q[25:21]) || (ex_rt_i == id_instr_q[20:16]))) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
    // An ack only counts against a request we actually have on the bus;
    // this also discards a stray ack in the first cycle after reset.
    if (req_q) begin
      ack_s = imem.imem_ack;
    end else begin
      ack_s = 1'b0;
    end
  end

  // Fetch FSM together with PC, IF/ID and skid buffer state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= 32'd0;
      addr_q       <= 32'd0;
      req_q        <= 1'b0;
      id_instr_q   <= 32'd0;
      id_pc4_q     <= 32'd0;
      id_valid_q   <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_pc4_q   <= 32'd0;
      skid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (redirect_i) begin
            pc_q         <= redirect_target_i;
            id_valid_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            if (req_q && !imem.imem_ack) begin
              // Request still in flight: keep it on the bus, drop its answer.
              state_q <= DROP;
            end else begin
              state_q <= FETCH;
              req_q   <= 1'b1;
              addr_q  <= redirect_target_i;
            end
          end else if (ack_s && !hazard_s) begin
            id_instr_q <= imem.imem_rdata;
            id_pc4_q   <= pc_plus4_s;
            id_valid_q <= 1'b1;
            pc_q       <= pc_plus4_s;
            addr_q     <= pc_plus4_s;
            if (rdata_halt_s) begin
              state_q  <= HALT;
              req_q    <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              state_q  <= FETCH;
              req_q    <= 1'b1;
            end
          end else if (ack_s) begin
            // IF/ID is held by the hazard, so park the word in the skid buffer.
            skid_instr_q <= imem.imem_rdata;
            skid_pc4_q   <= pc_plus4_s;
            skid_valid_q <= 1'b1;
            pc_q         <= pc_plus4_s;
            addr_q       <= pc_plus4_s;
            req_q        <= 1'b0;
            state_q      <= BUF;
          end else if (hazard_s) begin
            req_q <= 1'b1;
          end else begin
            id_valid_q <= 1'b0;
            req_q      <= 1'b1;
            addr_q     <= pc_q;
          end
        end
        BUF: begin
          if (redirect_i) begin
            pc_q         <= redirect_target_i;
            addr_q       <= redirect_target_i;
            id_valid_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            req_q        <= 1'b1;
            state_q      <= FETCH;
          end else if (!skid_valid_q) begin
            // Nothing parked: resume fetching.
            req_q   <= 1'b1;
            addr_q  <= pc_q;
            state_q <= FETCH;
          end else if (!hazard_s) begin
            id_instr_q   <= skid_instr_q;
            id_pc4_q     <= skid_pc4_q;
            id_valid_q   <= 1'b1;
            skid_valid_q <= 1'b0;
            if (skid_halt_s) begin
              state_q  <= HALT;
              req_q    <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              state_q  <= FETCH;
              req_q    <= 1'b1;
              addr_q   <= pc_q;
            end
          end else begin
            req_q <= 1'b0;
          end
        end
        DROP: begin
          if (redirect_i) begin
            pc_q <= redirect_target_i;
          end else begin
            pc_q <= pc_q;
          end
          if (ack_s) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
            addr_q  <= redirect_i ? redirect_target_i : pc_q;
          end else begin
            state_q <= DROP;
            req_q   <= 1'b1;
          end
        end
        HALT: begin
          req_q    <= 1'b0;
          halted_q <= 1'b1;
        end
        default: begin
          state_q    <= FETCH;
          req_q      <= 1'b0;
          id_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req    = req_q;
  assign imem.imem_addr   = addr_q;
  assign id_instruction_o = id_instr_q;
  assign id_pc_plus4_o    = id_pc4_q;
  assign stall_b_o        = id_valid_q & ~hazard_s;
  assign halted_o         = halted_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected IF/ID contents are queued when an
// accepted response is driven and compared when the stage should show them.
module tb_if_stage;
  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic [31:0] id_instruction;
  logic [31:0] id_pc_plus4;
  logic        stall_b;
  logic        halted;

  if_stage_if bus();

  if_stage dut (
    .clk               (clk),
    .rst               (rst),
    .imem              (bus),
    .redirect_i        (redirect),
    .redirect_target_i (redirect_target),
    .ex_mem_read_i     (ex_mem_read),
    .ex_rt_i           (ex_rt),
    .id_instruction_o  (id_instruction),
    .id_pc_plus4_o     (id_pc_plus4),
    .stall_b_o         (stall_b),
    .halted_o          (halted)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: observed=empty scoreboard expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_instr"}, id_instruction, e.instr);
      chk({tag, "_pc4"}, id_pc_plus4, e.pc4);
    end
  endtask

  // One accepted response: word expected in IF/ID with the given PC+4.
  task automatic ack_cycle(input logic [31:0] word, input logic [31:0] pc4);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    sb_q.push_back('{instr: word, pc4: pc4});
    step();
    bus.imem_ack = 1'b0;
    sb_check("fetch");
  endtask

  initial begin
    rst             = 1'b1;
    redirect        = 1'b0;
    redirect_target = 32'd0;
    ex_mem_read     = 1'b0;
    ex_rt           = 5'd0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'd0;
    repeat (3) step();

    // Reset values
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_instr", id_instruction, 32'd0);
    chk("rst_pc4", id_pc_plus4, 32'd0);
    chk("rst_stall_b", 32'(stall_b), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // Stray ack in first cycle after release is ignored
    rst            = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    chk("rel_req", 32'(bus.imem_req), 32'd1);
    chk("rel_addr", bus.imem_addr, 32'd0);
    chk("rel_instr", id_instruction, 32'd0);
    chk("rel_stall_b", 32'(stall_b), 32'd0);

    // Back-to-back fetches
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", bus.imem_addr, 32'(4 * i));
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'h20 + 32'(4 * i);
      sb_q.push_back('{instr: 32'h20 + 32'(4 * i), pc4: 32'(4 * i + 4)});
      step();
      sb_check("seq");
      chk("seq_stall_b", 32'(stall_b), 32'd1);
    end
    bus.imem_ack = 1'b0;

    // Load into $0 never stalls even though the fields are zero
    ex_mem_read = 1'b1;
    ex_rt       = 5'd0;
    #1;
    chk("rt0_stall_b", 32'(stall_b), 32'd1);
    ex_mem_read = 1'b0;

    // No ack -> bubble
    step();
    chk("bubble_stall_b", 32'(stall_b), 32'd0);
    chk("bubble_addr", bus.imem_addr, 32'd16);
    chk("bubble_req", 32'(bus.imem_req), 32'd1);

    // add $3,$2,$1 in IF/ID, then load-use on $2 with ack present
    ack_cycle(32'h0041_1820, 32'd20);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1111_1111;
    ex_mem_read    = 1'b1;
    ex_rt          = 5'd2;
    #1;
    chk("haz_stall_b", 32'(stall_b), 32'd0);
    sb_q.push_back('{instr: 32'h1111_1111, pc4: 32'd24});
    step();
    chk("buf_instr_held", id_instruction, 32'h0041_1820);
    chk("buf_req", 32'(bus.imem_req), 32'd0);
    bus.imem_ack = 1'b0;
    ex_mem_read  = 1'b0;
    #1;
    chk("buf_stall_b", 32'(stall_b), 32'd1);
    step();
    sb_check("skid");
    chk("skid_req", 32'(bus.imem_req), 32'd1);
    chk("skid_addr", bus.imem_addr, 32'd24);

    // Hazard on rt field without ack holds everything
    ex_mem_read = 1'b1;
    ex_rt       = 5'd17;
    #1;
    chk("hold_stall_b0", 32'(stall_b), 32'd0);
    step();
    chk("hold_instr", id_instruction, 32'h1111_1111);
    chk("hold_addr", bus.imem_addr, 32'd24);
    chk("hold_stall_b1", 32'(stall_b), 32'd0);
    ex_mem_read = 1'b0;
    #1;
    chk("hold_release", 32'(stall_b), 32'd1);

    // Redirect with request outstanding -> DROP, then async reset there
    redirect        = 1'b1;
    redirect_target = 32'h200;
    step();
    redirect = 1'b0;
    chk("drop_req", 32'(bus.imem_req), 32'd1);
    chk("drop_addr", bus.imem_addr, 32'd24);
    chk("drop_stall_b", 32'(stall_b), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", 32'(bus.imem_req), 32'd0);
    chk("arst_instr", id_instruction, 32'd0);
    chk("arst_pc4", id_pc_plus4, 32'd0);
    chk("arst_stall_b", 32'(stall_b), 32'd0);
    chk("arst_halted", 32'(halted), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("restart_req", 32'(bus.imem_req), 32'd1);
    chk("restart_addr", bus.imem_addr, 32'd0);

    // Redirect to 0x100 while request to 0x8 waits 3 cycles for its ack
    ack_cycle(32'h20, 32'd4);
    ack_cycle(32'h24, 32'd8);
    redirect        = 1'b1;
    redirect_target = 32'h100;
    step();
    redirect = 1'b0;
    chk("pend_addr", bus.imem_addr, 32'd8);
    chk("pend_stall_b", 32'(stall_b), 32'd0);
    step();
    step();
    chk("pend_addr_late", bus.imem_addr, 32'd8);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    step();
    bus.imem_ack = 1'b0;
    chk("redir_addr", bus.imem_addr, 32'h100);
    chk("redir_req", 32'(bus.imem_req), 32'd1);
    chk("redir_stall_b", 32'(stall_b), 32'd0);
    chk("redir_instr", id_instruction, 32'h24);

    // Redirect coincident with ack to 0xFFFFFFFC, then wrap
    bus.imem_ack    = 1'b1;
    bus.imem_rdata  = 32'h3333_3333;
    redirect        = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    bus.imem_ack = 1'b0;
    redirect     = 1'b0;
    chk("coinc_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("coinc_instr", id_instruction, 32'h24);
    chk("coinc_stall_b", 32'(stall_b), 32'd0);
    ack_cycle(32'h44, 32'd0);
    chk("wrap_addr", bus.imem_addr, 32'd0);

    // Halt word stops fetching; redirect afterwards is ignored
    ack_cycle(32'hFC00_0000, 32'd4);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_req", 32'(bus.imem_req), 32'd0);
    redirect        = 1'b1;
    redirect_target = 32'h300;
    step();
    redirect = 1'b0;
    step();
    chk("halt_req_after", 32'(bus.imem_req), 32'd0);
    chk("halt_halted_after", 32'(halted), 32'd1);
    chk("halt_instr_frozen", id_instruction, 32'hFC00_0000);
    chk("halt_pc4_frozen", id_pc_plus4, 32'd4);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
